// File: rtl/vga_pkg.sv
// Shared VGA timing types, standard mode presets and a helper that sums
// one axis of a timing description.
package vga_pkg;

    typedef struct packed {
        int unsigned visible;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_60 = '{
        h: '{visible: 640, front: 16, sync: 96,  back: 48},
        v: '{visible: 480, front: 10, sync: 2,   back: 33}
    };

    localparam vga_timing_t VGA_800X600_60 = '{
        h: '{visible: 800, front: 40, sync: 128, back: 88},
        v: '{visible: 600, front: 1,  sync: 4,   back: 23}
    };

    function automatic int unsigned axis_total(vga_axis_t a);
        return a.visible + a.front + a.sync + a.back;
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate clock enable: counts system clocks while en is high and pulses
// pix_tick on the last clock of every CLK_DIV-clock pixel period.
module vga_pixel_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic pix_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // Phase is held while en is low, so a paused pixel resumes where it stopped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    // Gated by rst_n so no tick is presented while reset is being applied.
    assign pix_tick = rst_n && en && (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: pixel enable, h/v counters and a
// registered sync/blank/coordinate decode one clock behind the counters.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = VGA_640X480_60.h.visible,
    parameter int H_FRONT   = VGA_640X480_60.h.front,
    parameter int H_SYNC    = VGA_640X480_60.h.sync,
    parameter int H_BACK    = VGA_640X480_60.h.back,
    parameter int V_VISIBLE = VGA_640X480_60.v.visible,
    parameter int V_FRONT   = VGA_640X480_60.v.front,
    parameter int V_SYNC    = VGA_640X480_60.v.sync,
    parameter int V_BACK    = VGA_640X480_60.v.back,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CLK_DIV   = 4,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             pix_tick,
    output logic             h_sync,
    output logic             v_sync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    localparam vga_axis_t H_AXIS = '{visible: H_VISIBLE, front: H_FRONT, sync: H_SYNC, back: H_BACK};
    localparam vga_axis_t V_AXIS = '{visible: V_VISIBLE, front: V_FRONT, sync: V_SYNC, back: V_BACK};
    localparam int H_TOTAL = int'(axis_total(H_AXIS));
    localparam int V_TOTAL = int'(axis_total(V_AXIS));
    localparam int EW      = CNT_W + 1;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [EW-1:0] H_DE_END = EW'(H_VISIBLE);
    localparam logic [EW-1:0] H_SS     = EW'(H_VISIBLE + H_FRONT);
    localparam logic [EW-1:0] H_SE     = EW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [EW-1:0] V_DE_END = EW'(V_VISIBLE);
    localparam logic [EW-1:0] V_SS     = EW'(V_VISIBLE + V_FRONT);
    localparam logic [EW-1:0] V_SE     = EW'(V_VISIBLE + V_FRONT + V_SYNC);

    if (longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
        longint'(V_TOTAL) > (longint'(1) << CNT_W) || CLK_DIV < 1) begin : g_bad_params
        $error("vga_timing_gen: totals exceed counter width or CLK_DIV < 1");
    end

    vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_pixel_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .pix_tick (pix_tick)
    );

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    logic [EW-1:0] h_ext;
    logic [EW-1:0] v_ext;
    logic          de_next;
    logic          hs_act;
    logic          vs_act;

    // Extended compare width so a sync or visible end equal to 2^CNT_W still works.
    always_comb begin
        h_ext   = {1'b0, h_cnt};
        v_ext   = {1'b0, v_cnt};
        de_next = (h_ext < H_DE_END) && (v_ext < V_DE_END);
        hs_act  = (h_ext >= H_SS) && (h_ext < H_SE);
        vs_act  = (v_ext >= V_SS) && (v_ext < V_SE);
    end

    logic             hs_q;
    logic             vs_q;
    logic             de_q;
    logic [CNT_W-1:0] x_q;
    logic [CNT_W-1:0] y_q;
    logic             ls_q;
    logic             fs_q;
    logic             new_pix;

    // new_pix marks that the counters moved on the previous tick, so the line
    // and frame pulses fire on a wrap but not on the (0,0) left by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_q    <= ~HSYNC_POL;
            vs_q    <= ~VSYNC_POL;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            new_pix <= 1'b0;
        end else if (en) begin
            hs_q    <= hs_act ? HSYNC_POL : ~HSYNC_POL;
            vs_q    <= vs_act ? VSYNC_POL : ~VSYNC_POL;
            de_q    <= de_next;
            x_q     <= de_next ? h_cnt : '0;
            y_q     <= de_next ? v_cnt : '0;
            ls_q    <= new_pix && (h_cnt == '0);
            fs_q    <= new_pix && (h_cnt == '0) && (v_cnt == '0);
            new_pix <= pix_tick;
        end
    end

    assign h_sync      = hs_q;
    assign v_sync      = vs_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = ls_q && en;
    assign frame_start = fs_q && en;

endmodule
